servo_bank_ctrl: RTL and testbench
==================================

// Module: servo_bank_ctrl
// PURPOSE
//  N-channel hobby-servo joint controller for the robot arm, replacing the fixed five-servo top level.
//  Jog buttons move the currently selected joint's position register, with clamping and hold-to-repeat.
//  All channels share one PWM frame counter; each channel emits a pulse whose width is set by its position.
//  Position changes take effect only at frame boundaries. The selected joint's position goes to the display.
// PARAMETERS
//  NUM_CH      5        number of servo channels (1..16)
//  POS_W       8        position register width
//  POS_MAX     200      max position; 0..POS_MAX maps to 1.0..2.0 ms pulse
//  POS_INIT    100      position loaded at reset (centre)
//  FRAME_TICKS 1000000  clk cycles per PWM frame (20 ms @ 50 MHz)
//  MIN_TICKS   50000    pulse width at position 0
//  TICK_PER_POS 250     extra pulse cycles per position unit
//  REPEAT_DLY  25000000 hold cycles before auto-repeat starts (0.5 s)
//  REPEAT_PER  2500000  cycles between auto-repeat steps (50 ms)
// PORTS
//  clk        in   1                  system clock, all logic on rising edge
//  rst_n      in   1                  asynchronous active-low reset
//  btn_up     in   1                  debounced level, increment selected joint
//  btn_dn     in   1                  debounced level, decrement selected joint
//  sel        in   $clog2(NUM_CH)     selected channel index
//  sel_valid  in   1                  1 = sel is meaningful; 0 = no joint selected
//  servo      out  NUM_CH             PWM pulse per channel
//  pos_out    out  POS_W              target position of the selected channel; 0 if !sel_valid or sel>=NUM_CH
//  frame_tick out  1                  1-cycle pulse on the last cycle of each frame
// BEHAVIOUR
//  Reset: every target and active position = POS_INIT, frame counter = 0, servo = 0, frame_tick = 0,
//   jog FSM = IDLE, repeat counter = 0. Reset is async assert and sync deassert.
//  Frame counter: counts 0..FRAME_TICKS-1 and wraps. frame_tick = (cnt == FRAME_TICKS-1).
//  servo[i] is registered: 1 while cnt < MIN_TICKS + active[i]*TICK_PER_POS, so the edge is cycle-exact.
//  Use FRAME_TICKS-width arithmetic for the pulse width; no truncation.
//  Each target[i] is copied to active[i] on frame_tick, so a frame never holds a mixed-width pulse.
//  Jog FSM (one, shared by all channels), dir = up XOR dn:
//   IDLE:   when exactly one button is pressed and the selection is valid, step once and go to DELAY.
//   DELAY:  count REPEAT_DLY; on expiry step once and go to REPEAT.
//   REPEAT: step every REPEAT_PER cycles.
//   Go to LOCK from DELAY or REPEAT when both buttons are pressed, when sel or sel_valid changes,
//    or when the selection becomes invalid.
//   Go to IDLE from DELAY or REPEAT when both buttons are released.
//   LOCK: no steps; leave for IDLE only when both buttons are released.
//   Both buttons pressed in IDLE: no step, stay in IDLE.
//  Step: target[sel] += 1 or -= 1, saturating at POS_MAX and 0 (no wrap). Only target[sel] changes.
//  A step taken on the frame_tick cycle itself commits in the same cycle (the new value is copied).
//  sel >= NUM_CH is treated as !sel_valid.
//  A reset mid-frame drives servo low immediately and restarts the frame from 0.
//  pos_out is combinational from target[sel]; latency from a step is 1 clk.
// STRUCTURE
//  Package servo_pkg holds: jog_state_t enum (IDLE, DELAY, REPEAT, LOCK), default timing constants,
//   and the function pulse_ticks(pos).
//  Sub-module servo_channel: target/active registers, saturating step, frame commit and PWM compare.
//   Generate NUM_CH instances of it.
//  The top level owns the frame counter, the jog FSM with its repeat counter, and the pos_out mux.
// TESTING (FRAME_TICKS=100, MIN_TICKS=10, TICK_PER_POS=1, POS_MAX=20, POS_INIT=10, REPEAT_DLY=30,
//  REPEAT_PER=5, NUM_CH=5)
//  1. Reset, no input -> every servo high 20 cycles per 100-cycle frame; pos_out = 0 with sel_valid=0.
//  2. sel=2, tap btn_up 3 cycles -> target[2]=11 after 1 clk; servo[2] stays 20 cycles high until the
//     next frame, then 21; other channels stay at 20.
//  3. Hold btn_up 60 cycles on sel=0 -> 1 step, 1 at cycle 30, then every 5 -> target=17 at release.
//  4. Hold btn_dn to saturation from 2 -> target reaches 0 and stays 0 (no wrap to 255);
//     from 19 up -> stays 20.
//  5. While in REPEAT, change sel 0->1 and keep btn_up held -> no further steps on either channel
//     until release, then a re-press steps channel 1.
//  6. Assert rst_n=0 mid-pulse (cnt=5) -> servo=0 at once and targets = 10; the first full frame
//     after release matches case 1.

Source files
------------

// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared types, default timing and pulse width helper for the servo bank
package servo_pkg;

    typedef enum logic [1:0] {
        JOG_IDLE   = 2'd0,
        JOG_DELAY  = 2'd1,
        JOG_REPEAT = 2'd2,
        JOG_LOCK   = 2'd3
    } jog_state_t;

    localparam int DEF_NUM_CH       = 5;
    localparam int DEF_POS_W        = 8;
    localparam int DEF_POS_MAX      = 200;
    localparam int DEF_POS_INIT     = 100;
    localparam int DEF_FRAME_TICKS  = 1000000;
    localparam int DEF_MIN_TICKS    = 50000;
    localparam int DEF_TICK_PER_POS = 250;
    localparam int DEF_REPEAT_DLY   = 25000000;
    localparam int DEF_REPEAT_PER   = 2500000;

    // High time of a pulse in clk cycles; 32-bit so no position/gain combo truncates.
    function automatic logic [31:0] pulse_ticks(input logic [31:0] pos,
                                                input logic [31:0] min_ticks,
                                                input logic [31:0] tick_per_pos);
        return min_ticks + pos * tick_per_pos;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// rtl/servo_channel.sv - one joint: target/active position, saturating step, frame commit, PWM
module servo_channel
    import servo_pkg::*;
#(
    parameter int POS_W        = DEF_POS_W,
    parameter int POS_MAX      = DEF_POS_MAX,
    parameter int POS_INIT     = DEF_POS_INIT,
    parameter int CNT_W        = 20,
    parameter int MIN_TICKS    = DEF_MIN_TICKS,
    parameter int TICK_PER_POS = DEF_TICK_PER_POS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_en,
    input  logic             step_up,
    input  logic             commit,
    input  logic [CNT_W-1:0] cnt_next,
    output logic             servo,
    output logic [POS_W-1:0] target
);

    logic [POS_W-1:0] target_q, target_d;
    logic [POS_W-1:0] active_q, active_d;
    logic             servo_q, servo_d;

    // Saturating step, commit at frame end (same-cycle step included), and compare
    // against the next counter value so servo_q edges land on the exact count.
    always_comb begin
        target_d = target_q;
        if (step_en) begin
            if (step_up) begin
                if (target_q < POS_W'(POS_MAX)) begin
                    target_d = target_q + 1'b1;
                end
            end else if (target_q != '0) begin
                target_d = target_q - 1'b1;
            end
        end
        active_d = commit ? target_d : active_q;
        servo_d  = 32'(cnt_next) < pulse_ticks(32'(active_d), 32'(MIN_TICKS), 32'(TICK_PER_POS));
    end

    // Position and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= POS_W'(POS_INIT);
            active_q <= POS_W'(POS_INIT);
            servo_q  <= 1'b0;
        end else begin
            target_q <= target_d;
            active_q <= active_d;
            servo_q  <= servo_d;
        end
    end

    assign servo  = servo_q;
    assign target = target_q;

endmodule

// File: rtl/servo_bank_ctrl.sv
// rtl/servo_bank_ctrl.sv - N-channel servo controller: frame counter, jog FSM, position readout
module servo_bank_ctrl
    import servo_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int POS_W        = DEF_POS_W,
    parameter int POS_MAX      = DEF_POS_MAX,
    parameter int POS_INIT     = DEF_POS_INIT,
    parameter int FRAME_TICKS  = DEF_FRAME_TICKS,
    parameter int MIN_TICKS    = DEF_MIN_TICKS,
    parameter int TICK_PER_POS = DEF_TICK_PER_POS,
    parameter int REPEAT_DLY   = DEF_REPEAT_DLY,
    parameter int REPEAT_PER   = DEF_REPEAT_PER,
    localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W       = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_up,
    input  logic              btn_dn,
    input  logic [SEL_W-1:0]  sel,
    input  logic              sel_valid,
    output logic [NUM_CH-1:0] servo,
    output logic [POS_W-1:0]  pos_out,
    output logic              frame_tick
);

    localparam logic [31:0] NUM_CH_U = 32'(NUM_CH);
    localparam logic [31:0] DLY_LAST = 32'(REPEAT_DLY - 1);
    localparam logic [31:0] PER_LAST = 32'(REPEAT_PER - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    jog_state_t       state_q, state_d;
    logic [31:0]      rpt_q, rpt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             sel_valid_q, sel_valid_d;
    logic             sel_ok, sel_chg, step;
    logic [POS_W-1:0] target_w [NUM_CH];

    assign sel_ok     = sel_valid && (32'(sel) < NUM_CH_U);
    assign sel_chg    = (sel != sel_q) || (sel_valid != sel_valid_q);
    assign frame_tick = (cnt_q == CNT_W'(FRAME_TICKS - 1));

    // Free-running frame counter; also remembers last selection for change detection.
    always_comb begin
        cnt_d       = frame_tick ? '0 : cnt_q + 1'b1;
        sel_d       = sel;
        sel_valid_d = sel_valid;
    end

    // Jog FSM: single step on press, delayed auto-repeat, lockout until full release.
    always_comb begin
        state_d = state_q;
        rpt_d   = rpt_q;
        step    = 1'b0;
        case (state_q)
            JOG_IDLE: begin
                if ((btn_up ^ btn_dn) && sel_ok) begin
                    step    = 1'b1;
                    state_d = JOG_DELAY;
                    rpt_d   = '0;
                end
            end
            JOG_DELAY, JOG_REPEAT: begin
                if (!btn_up && !btn_dn) begin
                    state_d = JOG_IDLE;
                    rpt_d   = '0;
                end else if ((btn_up && btn_dn) || sel_chg || !sel_ok) begin
                    state_d = JOG_LOCK;
                    rpt_d   = '0;
                end else if (rpt_q == ((state_q == JOG_DELAY) ? DLY_LAST : PER_LAST)) begin
                    step    = 1'b1;
                    state_d = JOG_REPEAT;
                    rpt_d   = '0;
                end else begin
                    rpt_d   = rpt_q + 1'b1;
                end
            end
            default: begin
                if (!btn_up && !btn_dn) begin
                    state_d = JOG_IDLE;
                end
            end
        endcase
    end

    // Frame counter, FSM and selection history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            state_q     <= JOG_IDLE;
            rpt_q       <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            rpt_q       <= rpt_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_channel #(
            .POS_W       (POS_W),
            .POS_MAX     (POS_MAX),
            .POS_INIT    (POS_INIT),
            .CNT_W       (CNT_W),
            .MIN_TICKS   (MIN_TICKS),
            .TICK_PER_POS(TICK_PER_POS)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .step_en (step && (sel == SEL_W'(i))),
            .step_up (btn_up),
            .commit  (frame_tick),
            .cnt_next(cnt_d),
            .servo   (servo[i]),
            .target  (target_w[i])
        );
    end

    // Selected joint's target for the display; zero when nothing valid is selected.
    always_comb begin
        pos_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_ok && (sel == SEL_W'(i))) begin
                pos_out = target_w[i];
            end
        end
    end

endmodule

// File: tb/tb_servo_bank_ctrl.sv
// tb/tb_servo_bank_ctrl.sv - directed self-checking bench for servo_bank_ctrl
module tb_servo_bank_ctrl;

    localparam int NCH = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           btn_up, btn_dn;
    logic [2:0]     sel;
    logic           sel_valid;
    logic [NCH-1:0] servo;
    logic [7:0]     pos_out;
    logic           frame_tick;

    int total = 0;
    int bad   = 0;
    int hc [NCH];
    int tick_at;

    servo_bank_ctrl #(
        .NUM_CH(NCH), .POS_W(8), .POS_MAX(20), .POS_INIT(10), .FRAME_TICKS(100),
        .MIN_TICKS(10), .TICK_PER_POS(1), .REPEAT_DLY(30), .REPEAT_PER(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn), .sel(sel),
        .sel_valid(sel_valid), .servo(servo), .pos_out(pos_out), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        while (frame_tick !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_frame();
        tick_at = -1;
        for (int c = 0; c < NCH; c++) hc[c] = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) hc[c] += int'(servo[c]);
            if (frame_tick === 1'b1 && tick_at < 0) tick_at = k;
        end
    endtask

    task automatic chk_widths(input string tag, input int w0, input int w1, input int w2,
                              input int w3, input int w4);
        int w [NCH];
        w = '{w0, w1, w2, w3, w4};
        for (int c = 0; c < NCH; c++) chk($sformatf("%s_ch%0d", tag, c), hc[c], w[c]);
    endtask

    task automatic rd(input string tag, input int ch, input int exp);
        sel = 3'(ch);
        sel_valid = 1'b1;
        @(negedge clk);
        chk(tag, pos_out, exp);
    endtask

    task automatic tap(input bit up);
        if (up) btn_up = 1'b1; else btn_dn = 1'b1;
        @(negedge clk);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        @(negedge clk);
    endtask

    task automatic hold(input bit up, input int n);
        if (up) btn_up = 1'b1; else btn_dn = 1'b1;
        repeat (n) @(negedge clk);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; sel = 3'd2; sel_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_servo", servo, 0);
        chk("rst_tick", frame_tick, 0);
        chk("rst_pos_invalid", pos_out, 0);
        rst_n = 1'b1;

        // 1: idle frame, every channel at centre width
        wait_tick();
        count_frame();
        chk_widths("idle", 20, 20, 20, 20, 20);
        chk("tick_last_cycle", tick_at, 99);
        chk("pos_invalid", pos_out, 0);
        rd("pos_sel4", 4, 10);
        rd("pos_sel5_oob", 5, 0);
        rd("pos_sel7_oob", 7, 0);
        sel = 3'd6;
        tap(1'b1);
        rd("oob_no_step", 4, 10);

        // 2: tap up on joint 2 mid-frame; width changes only next frame
        sel = 3'd2;
        sel_valid = 1'b1;
        wait_tick();
        for (int c = 0; c < NCH; c++) hc[c] = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) hc[c] += int'(servo[c]);
            if (k == 5) btn_up = 1'b1;
            if (k == 6) chk("tap_latency", pos_out, 11);
            if (k == 8) btn_up = 1'b0;
        end
        chk_widths("tap_same_frame", 20, 20, 20, 20, 20);
        wait_tick();
        count_frame();
        chk_widths("tap_next_frame", 20, 20, 21, 20, 20);

        // 3: hold up 60 cycles on joint 0
        sel = 3'd0;
        @(negedge clk);
        btn_up = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 0)  chk("hold_first", pos_out, 11);
            if (i == 29) chk("hold_delay", pos_out, 11);
            if (i == 30) chk("hold_repeat1", pos_out, 12);
        end
        btn_up = 1'b0;
        @(negedge clk);
        chk("hold_release", pos_out, 17);

        // 4: saturation at both ends on joint 1
        sel = 3'd1;
        @(negedge clk);
        repeat (8) tap(1'b0);
        chk("dn_to_2", pos_out, 2);
        hold(1'b0, 60);
        chk("sat_zero", pos_out, 0);
        tap(1'b0);
        chk("sat_zero_tap", pos_out, 0);
        repeat (19) tap(1'b1);
        chk("up_to_19", pos_out, 19);
        hold(1'b1, 60);
        chk("sat_max", pos_out, 20);

        // 5: selection change during repeat locks out further steps
        sel = 3'd3;
        @(negedge clk);
        btn_up = 1'b1;
        repeat (37) @(negedge clk);
        chk("lock_pre", pos_out, 13);
        sel = 3'd4;
        repeat (40) @(negedge clk);
        chk("lock_ch4", pos_out, 10);
        sel = 3'd3;
        @(negedge clk);
        chk("lock_ch3", pos_out, 13);
        btn_up = 1'b0;
        repeat (2) @(negedge clk);
        sel = 3'd4;
        @(negedge clk);
        tap(1'b1);
        chk("repress_ch4", pos_out, 11);
        rd("ch3_kept", 3, 13);

        // mixed widths including the min and max positions
        wait_tick();
        count_frame();
        chk_widths("mixed", 27, 30, 21, 23, 21);

        // 6: reset mid-pulse
        repeat (6) @(negedge clk);
        chk("pre_reset_high", servo, 5'h1f);
        rst_n = 1'b0;
        #1;
        chk("reset_servo_now", servo, 0);
        sel = 3'd1;
        #1;
        chk("reset_target", pos_out, 10);
        @(negedge clk);
        rst_n = 1'b1;
        sel_valid = 1'b0;
        wait_tick();
        count_frame();
        chk_widths("post_reset", 20, 20, 20, 20, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
